afifo_wr_arbiter: RTL
=====================

// Module: afifo_wr_arbiter
// PURPOSE
//  N-requester round-robin arbiter sharing the single async-FIFO write port (winc/wdata/wfull).
//  Sits in the write clock domain between producer engines and the FIFO write side.
//  Registered single-entry output stage; FIFO-full backpressure propagates to requesters via valid/ready.
// PARAMETERS
//  DATA_WIDTH  32  width of wdata and of each requester data lane
//  NUM_REQ      4  number of requesters, 2..16
//  MAX_BURST    8  max beats one owner keeps the grant (used only with AFIFO_ARB_BURST_EN)
// PORTS
//  wclk       in   1                  write-domain clock; single clock for the block
//  wrst       in   1                  synchronous, active-high reset
//  req_valid  in   NUM_REQ            per-requester beat valid
//  req_data   in   NUM_REQ*DATA_WIDTH packed lanes; lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last   in   NUM_REQ            last beat of a requester's burst (ignored without burst feature)
//  req_ready  out  NUM_REQ            beat accepted when req_valid[i] & req_ready[i]
//  winc       out  1                  FIFO write strobe
//  wdata      out  DATA_WIDTH         FIFO write data
//  wfull      in   1                  FIFO full flag
//  grant_id   out  $clog2(NUM_REQ)    index of current/last granted requester
// BEHAVIOUR
//  - Reset (wrst=1 at wclk edge): out_vld=0, winc=0, wdata=0, req_ready=0, grant_id=0, rr pointer=0, state=IDLE, beat_cnt=0.
//  - Output stage: out_vld/out_data register. winc = out_vld & ~wfull (combinational); wdata = out_data.
//    Stage drains when winc=1; stage can load when ~out_vld | winc (load-while-drain allowed).
//  - req_ready[i] = (i==selected) & can_load; at most one bit set per cycle; never set during reset.
//  - Latency: accepted beat appears on winc/wdata the next cycle if wfull=0; held stable while wfull=1.
//  - Selection: first requester with req_valid set, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
//  - FSM IDLE: select per round-robin; on accept -> record owner in grant_id, rr_ptr <= owner+1 (mod NUM_REQ);
//    go to OWN only if burst feature on and beat not terminal.
//  - FSM OWN: only owner eligible; beat_cnt++ per accepted beat; terminal beat = req_last | beat_cnt==MAX_BURST-1;
//    on terminal beat -> IDLE, beat_cnt=0. Owner dropping req_valid mid-burst: stay OWN (no timeout).
//  - wfull=1 with out_vld=1: all req_ready=0, out_data unchanged, no beat lost or duplicated.
//  - wfull toggling: beat written exactly once, on the first cycle with out_vld=1 and wfull=0.
//  - Simultaneous drain+accept: both occur in same cycle; throughput 1 beat/cycle when wfull=0.
//  - Single requester: granted every cycle, no bubbles.
//  - Reset mid-operation: buffered beat discarded, FSM to IDLE; requesters must re-present data.
//  - NUM_REQ not a power of two: pointer wraps explicitly; grant_id never >= NUM_REQ.
// CONFIGURATION
//  AFIFO_ARB_BURST_EN defined: OWN state active; owner holds grant until req_last or MAX_BURST beats.
//  Not defined: FSM never leaves IDLE; grant rotates after every accepted beat; req_last and MAX_BURST unused.
// STRUCTURE
//  Package afifo_arb_pkg: arb_state_e {IDLE, OWN}; function rr_next(ptr, n); REQ_IDX_W localparam helper.
//  Sub-module afifo_rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> hit, index).
//  Top holds FSM, beat counter, rr pointer and output stage.
// TESTING
//  1. NUM_REQ=4, all req_valid=1, wfull=0, no burst -> grant_id cycles 0,1,2,3,0; winc=1 every cycle after first.
//  2. Only req 2 valid, 10 beats 0xA0..0xA9 -> wdata 0xA0..0xA9 in order, one cycle after each accept.
//  3. wfull=1 for 5 cycles holding beat 0x55 -> winc=0, req_ready=0, wdata=0x55; wfull=0 -> one write of 0x55.
//  4. BURST_EN, MAX_BURST=8, req0 12 beats no req_last, req1 valid -> 8 beats from req0, then req1 granted.
//  5. BURST_EN, req3 asserts req_last on beat 3 -> grant released after 3 beats; rr_ptr=0.
//  6. wrst=1 mid-burst with out_vld=1 -> next cycle winc=0, grant_id=0, state IDLE; no stale beat written.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port round-robin arbiter.
package afifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_NUM_REQ = 16;
  localparam int unsigned REQ_IDX_W   = $clog2(MAX_NUM_REQ);

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin successor with explicit wrap, so non-power-of-two counts stay in range.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or above ptr_i, wrapping at NUM_REQ-1.
module afifo_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand;
  logic             found;

  // One extra bit holds ptr+k before the explicit wrap back into [0, NUM_REQ).
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter in front of the async-FIFO write port with a one-entry output stage.
// Define AFIFO_ARB_BURST_EN to let an owner keep the grant until req_last or MAX_BURST beats.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                            wclk,
  input  logic                            wrst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            winc,
  output logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            wfull,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned IDX_W  = req_idx_w(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [NUM_REQ-1:0]    owner_mask;
  logic [NUM_REQ-1:0]    eligible;
  logic                  pick_hit;
  logic [IDX_W-1:0]      pick_idx;
  logic                  drain;
  logic                  can_load;
  logic                  accept;
  logic                  terminal;
  logic [DATA_WIDTH-1:0] sel_data;
`ifdef AFIFO_ARB_BURST_EN
  logic                  sel_last;
`else
  logic                  unused_last;
  assign unused_last = ^req_last;
`endif

  // While a burst is owned only the owner may compete; rr_ptr is left untouched.
  assign owner_mask = NUM_REQ'(1) << grant_id_q;
  assign eligible   = (state_q == OWN) ? (req_valid & owner_mask) : req_valid;

  // A buffered beat is never written in the reset cycle, so nothing stale reaches the FIFO.
  assign drain    = out_vld_q & ~wfull & ~wrst;
  assign can_load = (~out_vld_q | drain) & ~wrst;

  assign winc     = drain;
  assign wdata    = out_data_q;
  assign grant_id = grant_id_q;

  afifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  // State register
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !terminal) state_d = OWN;
      OWN:     if (accept && terminal)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake, lane select and datapath next values
  always_comb begin
    sel_data = '0;
`ifdef AFIFO_ARB_BURST_EN
    sel_last = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef AFIFO_ARB_BURST_EN
        sel_last = req_last[i];
`endif
      end
    end

    accept = pick_hit & can_load;
`ifdef AFIFO_ARB_BURST_EN
    terminal = sel_last | (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
`else
    terminal = 1'b1;
`endif

    req_ready = '0;
    if (accept) begin
      req_ready[pick_idx] = 1'b1;
    end

    out_vld_d  = accept | (out_vld_q & ~drain);
    out_data_d = accept ? sel_data : out_data_q;
    grant_id_d = accept ? pick_idx : grant_id_q;

    rr_ptr_d = rr_ptr_q;
    if (accept && (state_q == IDLE)) begin
      rr_ptr_d = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
    end

    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      beat_cnt_d = terminal ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
